// File: rtl/dsss_pn_spread_ctrl.sv
`default_nettype none
// ============================================================================
// dsss_pn_spread_ctrl : DSSS PN spreading sequencer (LFSR, chip timing, framing, bit intake)
// Revision 1.0
// ============================================================================
module dsss_pn_spread_ctrl #(
  parameter int             LEN      = 5,
  parameter int             CHIP_DIV = 1,
  parameter int             DIV_W    = 8,
  parameter logic [LEN:0]   POLY_RST = 6'b100101,
  parameter logic [LEN-1:0] SEED_RST = 5'b10000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [LEN:0]   cfg_poly,
  input  logic [LEN-1:0] cfg_seed,
  output logic           seed_err,
  input  logic           start,
  input  logic           stop,
  input  logic           din_valid,
  input  logic           din,
  output logic           din_ready,
  output logic           chip_en,
  output logic           chip_out,
  output logic           pn_out,
  output logic           epoch,
  output logic           underrun,
  output logic           busy
);

  localparam int               N         = (1 << LEN) - 1;
  localparam logic [LEN-1:0]   LAST_CHIP = LEN'(N - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CHIP_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t           state;
  logic [LEN:0]     poly;
  logic [LEN-1:0]   seed;
  logic [LEN-1:0]   lfsr;
  logic [DIV_W-1:0] div_cnt;
  logic [LEN-1:0]   chip_cnt;
  logic             nxt_full;
  logic             nxt_bit;
  logic             cur_bit;
  logic             stop_pend;

  logic fb;
  logic active;
  logic tick;
  logic chip0;
  logic chip_bit;
  logic din_acc;
  logic poly_unused;

  assign active    = (state == RUN) || (state == DRAIN);
  assign tick      = active && (div_cnt == DIV_LAST);
  assign chip0     = (chip_cnt == '0);
  // A symbol with nothing buffered is spread with a zero bit.
  assign chip_bit  = chip0 ? (nxt_full & nxt_bit) : cur_bit;
  assign din_ready = active && !nxt_full;
  assign din_acc   = din_valid && din_ready;
  assign cfg_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  // The x^0 and x^LEN terms are implicit in the Fibonacci feedback.
  assign poly_unused = poly[LEN] ^ poly[0];

  always_comb begin
    fb = lfsr[LEN-1];
    for (int j = 0; j < LEN - 1; j++) begin
      fb = fb ^ (poly[j+1] & lfsr[j]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      poly      <= POLY_RST;
      seed      <= SEED_RST;
      lfsr      <= '0;
      div_cnt   <= '0;
      chip_cnt  <= '0;
      nxt_full  <= 1'b0;
      nxt_bit   <= 1'b0;
      cur_bit   <= 1'b0;
      stop_pend <= 1'b0;
      chip_en   <= 1'b0;
      chip_out  <= 1'b0;
      pn_out    <= 1'b0;
      epoch     <= 1'b0;
      underrun  <= 1'b0;
      seed_err  <= 1'b0;
    end else begin
      chip_en  <= 1'b0;
      epoch    <= 1'b0;
      underrun <= 1'b0;
      seed_err <= 1'b0;

      case (state)
        IDLE: begin
          if (cfg_valid) begin
            if (cfg_seed != '0) begin
              poly <= cfg_poly;
              seed <= cfg_seed;
            end else begin
              seed_err <= 1'b1;
            end
          end
          if (start) begin
            state <= LOAD;
          end
        end

        LOAD: begin
          lfsr      <= seed;
          chip_cnt  <= '0;
          div_cnt   <= '0;
          stop_pend <= 1'b0;
          state     <= RUN;
        end

        RUN, DRAIN: begin
          if (tick) begin
            div_cnt  <= '0;
            pn_out   <= lfsr[LEN-1];
            chip_out <= lfsr[LEN-1] ^ chip_bit;
            chip_en  <= 1'b1;
            epoch    <= chip0;
            if (chip0) begin
              cur_bit  <= chip_bit;
              nxt_full <= 1'b0;
              underrun <= !nxt_full;
            end
            // Every symbol restarts from the seed phase.
            if (chip_cnt == LAST_CHIP) begin
              lfsr     <= seed;
              chip_cnt <= '0;
              if (stop_pend) begin
                state <= IDLE;
              end
            end else begin
              lfsr     <= {lfsr[LEN-2:0], fb};
              chip_cnt <= chip_cnt + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
          if ((state == RUN) && stop) begin
            stop_pend <= 1'b1;
            state     <= DRAIN;
          end
        end

        default: state <= IDLE;
      endcase

      // Placed after the chip-0 consume so a same-cycle accept is kept for the next symbol.
      if (din_acc) begin
        nxt_full <= 1'b1;
        nxt_bit  <= din;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dsss_pn_spread_ctrl.sv
`default_nettype none
// ============================================================================
// tb_dsss_pn_spread_ctrl : table-driven, scoreboarded bench for the PN spreader
// Revision 1.0
// ============================================================================
module tb_dsss_pn_spread_ctrl;

  localparam logic [5:0] DEF_POLY = 6'b100101;
  localparam logic [4:0] DEF_SEED = 5'b10000;
  localparam logic [5:0] ALT_POLY = 6'b101001;
  localparam logic [4:0] ALT_SEED = 5'b00001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       cfg_valid, start, stop, din_valid, din;
  logic [5:0] cfg_poly;
  logic [4:0] cfg_seed;
  logic       cfg_ready, seed_err, din_ready, chip_en, chip_out, pn_out, epoch, underrun, busy;

  logic       cfg_valid4, start4, stop4, din_valid4, din4;
  logic [5:0] cfg_poly4;
  logic [4:0] cfg_seed4;
  logic       cfg_ready4, seed_err4, din_ready4, chip_en4, chip_out4, pn_out4, epoch4, underrun4, busy4;

  dsss_pn_spread_ctrl dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_poly(cfg_poly), .cfg_seed(cfg_seed), .seed_err(seed_err),
    .start(start), .stop(stop), .din_valid(din_valid), .din(din), .din_ready(din_ready),
    .chip_en(chip_en), .chip_out(chip_out), .pn_out(pn_out), .epoch(epoch),
    .underrun(underrun), .busy(busy)
  );

  dsss_pn_spread_ctrl #(.CHIP_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid4), .cfg_ready(cfg_ready4),
    .cfg_poly(cfg_poly4), .cfg_seed(cfg_seed4), .seed_err(seed_err4),
    .start(start4), .stop(stop4), .din_valid(din_valid4), .din(din4), .din_ready(din_ready4),
    .chip_en(chip_en4), .chip_out(chip_out4), .pn_out(pn_out4), .epoch(epoch4),
    .underrun(underrun4), .busy(busy4)
  );

  typedef struct packed {
    logic ep;
    logic pn;
    logic ch;
    logic un;
  } chip_t;

  typedef struct packed {
    logic supply;
    logic sbit;
    logic late;
    logic exp_bit;
    logic exp_und;
  } sym_t;

  int    nvec = 0;
  int    nfail = 0;
  chip_t exp_q[$];
  logic  obs_pn[$];
  logic  obs_ch[$];
  sym_t  tbl[5];

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [30:0] pn_seq(input logic [5:0] p, input logic [4:0] s);
    logic [4:0] l;
    logic       f;
    l = s;
    pn_seq = '0;
    for (int i = 0; i < 31; i++) begin
      pn_seq[i] = l[4];
      f = l[4];
      for (int j = 0; j < 4; j++) f = f ^ (p[j+1] & l[j]);
      l = {l[3:0], f};
    end
  endfunction

  function automatic int pack6(input logic q[$]);
    int v;
    v = 0;
    for (int i = 0; i < 6; i++) v = (v << 1) | ((i < q.size()) ? int'(q[i]) : 0);
    return v;
  endfunction

  task automatic push_symbol(input logic [5:0] p, input logic [4:0] s, input logic b, input logic u);
    logic [30:0] q;
    q = pn_seq(p, s);
    for (int i = 0; i < 31; i++) exp_q.push_back(chip_t'({(i == 0), q[i], q[i] ^ b, (i == 0) & u}));
  endtask

  task automatic wait_epoch();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (chip_en && epoch) got = 1'b1;
    end
    if (!got) chk("epoch_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (!busy) got = 1'b1;
    end
    if (!got) chk("idle_timeout", 0, 1);
  endtask

  task automatic offer(input logic b);
    bit done;
    done = 1'b0;
    din_valid = 1'b1;
    din = b;
    for (int i = 0; i < 100 && !done; i++) begin
      if (din_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    din_valid = 1'b0;
    if (!done) chk("din_accept_timeout", 0, 1);
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic finish_run(input string tag);
    wait_idle();
    chk({tag, "_final_chip_with_idle"}, int'(chip_en), 1);
    repeat (5) @(negedge clk);
    chk({tag, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    logic [30:0] s;
    int idx, last, cyc, extra;
    bit done;
    chip_t e;

    rst = 1'b1;
    cfg_valid = 1'b0; start = 1'b0; stop = 1'b0; din_valid = 1'b0; din = 1'b0;
    cfg_poly = '0; cfg_seed = '0;
    cfg_valid4 = 1'b0; start4 = 1'b0; stop4 = 1'b0; din_valid4 = 1'b0; din4 = 1'b0;
    cfg_poly4 = '0; cfg_seed4 = '0;

    // stream {start-of-symbol, bit, expectation} per symbol of the main run
    tbl[0] = '{supply: 1'b1, sbit: 1'b0, late: 1'b0, exp_bit: 1'b1, exp_und: 1'b0};
    tbl[1] = '{supply: 1'b1, sbit: 1'b1, late: 1'b0, exp_bit: 1'b0, exp_und: 1'b0};
    tbl[2] = '{supply: 1'b0, sbit: 1'b0, late: 1'b0, exp_bit: 1'b1, exp_und: 1'b0};
    tbl[3] = '{supply: 1'b1, sbit: 1'b1, late: 1'b1, exp_bit: 1'b0, exp_und: 1'b1};
    tbl[4] = '{supply: 1'b1, sbit: 1'b0, late: 1'b0, exp_bit: 1'b1, exp_und: 1'b0};

    fork
      forever begin
        @(negedge clk);
        if (chip_en) begin
          obs_pn.push_back(pn_out);
          obs_ch.push_back(chip_out);
          if (exp_q.size() == 0) begin
            chk("unexpected_chip", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("chip{ep,pn,ch,un}", int'({epoch, pn_out, chip_out, underrun}), int'(e));
          end
        end else if (underrun) begin
          chk("stray_underrun", 1, 0);
        end
      end
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_outs{en,ch,pn,ep,un,se,dr,busy}",
        int'({chip_en, chip_out, pn_out, epoch, underrun, seed_err, din_ready, busy}), 0);
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    chk("rst_cfg_ready4", int'({cfg_ready4, busy4, din_ready4, seed_err4}), 4'b1000);
    rst = 1'b0;
    @(negedge clk);

    // CHIP_DIV=4: spacing, stop at chip 10, full drain to chip 30
    s = pn_seq(DEF_POLY, DEF_SEED);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    idx = 0; last = -1; cyc = 0; done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      cyc++;
      if (stop4) stop4 = 1'b0;
      if (chip_en4) begin
        if (last >= 0) chk("div4_spacing", cyc - last, 4);
        chk("div4_chip{ep,un,pn,ch}", int'({epoch4, underrun4, pn_out4, chip_out4}),
            (idx < 31) ? int'({(idx == 0), (idx == 0), s[idx], s[idx]}) : 16);
        last = cyc;
        if (idx == 10) stop4 = 1'b1;
        idx++;
      end
      if (!busy4) done = 1'b1;
    end
    chk("div4_chip_count", idx, 31);
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (chip_en4) extra++;
    end
    chk("div4_no_chip_after_drain", extra, 0);

    // Zero seed rejected, config unchanged; priming run leaves a 1 buffered
    cfg_valid = 1'b1; cfg_poly = ALT_POLY; cfg_seed = 5'b00000;
    @(negedge clk);
    chk("seed_err_pulse", int'(seed_err), 1);
    cfg_valid = 1'b0;
    @(negedge clk);
    chk("seed_err_clear", int'(seed_err), 0);

    push_symbol(DEF_POLY, DEF_SEED, 1'b0, 1'b1);
    start = 1'b1; din_valid = 1'b1; din = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("load_din_ready", int'(din_ready), 0);
    @(negedge clk);
    chk("run_din_ready", int'(din_ready), 1);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    @(negedge clk);
    chk("chip0_accept_kept", int'({din_ready, underrun}), 2'b01);
    repeat (3) @(negedge clk);
    pulse_stop();
    finish_run("prime");

    // Main table-driven run, buffered 1 used for symbol 0
    obs_pn.delete(); obs_ch.delete();
    for (int k = 0; k < 5; k++) push_symbol(DEF_POLY, DEF_SEED, tbl[k].exp_bit, tbl[k].exp_und);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_c1{en,busy,cfg_ready}", int'({chip_en, busy, cfg_ready}), 3'b010);
    @(negedge clk);
    chk("start_c2{en,din_ready}", int'({chip_en, din_ready}), 0);
    @(negedge clk);
    chk("start_c3{en,epoch}", int'({chip_en, epoch}), 3);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) wait_epoch();
      if (tbl[k].supply) begin
        if (tbl[k].late) begin
          chk("din_ready_wait", int'(din_ready), 1);
          repeat (8) @(negedge clk);
          chk("din_ready_hold", int'(din_ready), 1);
        end
        offer(tbl[k].sbit);
      end
      if (k == 4) begin
        repeat (5) @(negedge clk);
        pulse_stop();
      end
    end
    finish_run("main");
    chk("main_first6_pn", pack6(obs_pn), 6'b100001);
    chk("main_first6_chip", pack6(obs_ch), 6'b011110);
    chk("main_chip_total", obs_pn.size(), 155);

    // New config accepted together with start; buffered 0 from the main run
    obs_pn.delete(); obs_ch.delete();
    push_symbol(ALT_POLY, ALT_SEED, 1'b0, 1'b0);
    push_symbol(ALT_POLY, ALT_SEED, 1'b1, 1'b0);
    cfg_valid = 1'b1; cfg_poly = ALT_POLY; cfg_seed = ALT_SEED; start = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b0;
    chk("good_cfg_no_seed_err", int'(seed_err), 0);
    wait_epoch();
    offer(1'b1);
    wait_epoch();
    repeat (5) @(negedge clk);
    pulse_stop();
    finish_run("alt");
    chk("alt_first_pn", (obs_pn.size() > 0) ? int'(obs_pn[0]) : 2, 0);

    // Async reset mid-symbol, then default sequence again
    push_symbol(ALT_POLY, ALT_SEED, 1'b0, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_epoch();
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_outs{en,ch,pn,ep,un,dr,busy}",
        int'({chip_en, chip_out, pn_out, epoch, underrun, din_ready, busy}), 0);
    chk("async_rst_cfg_ready", int'(cfg_ready), 1);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    obs_pn.delete(); obs_ch.delete();
    push_symbol(DEF_POLY, DEF_SEED, 1'b0, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_epoch();
    repeat (8) @(negedge clk);
    pulse_stop();
    finish_run("post_rst");
    chk("post_rst_first6_pn", pack6(obs_pn), 6'b100001);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dsss_pn_spread_ctrl.md
Name: dsss_pn_spread_ctrl

Overview:
- Sequencing controller for the DSSS modulator PN spreading path.
- Owns a configurable Fibonacci LFSR, chip-rate timing, symbol framing and the data-bit intake handshake.
- Emits one spread chip per chip tick: PN chip XOR current data bit.
- Sits between the baseband bit source and the carrier modulator; the PN polynomial and seed are reprogrammed through a config handshake while idle.

Parameters:
- LEN, 5, LFSR length; symbol length N = 2^LEN-1 chips (31).
- CHIP_DIV, 1, system clocks per chip (1 gives 31×Rb clock = chip rate); must be >= 1.
- DIV_W, 8, width of the chip divider counter; requires CHIP_DIV <= 2^DIV_W.
- POLY_RST, 6'b100101, polynomial loaded at reset (LEN+1 bits).
- SEED_RST, 5'b10000, seed loaded at reset (LEN bits).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accept, high only in IDLE
- cfg_poly  in  LEN+1  polynomial; bit k = x^k coefficient
- cfg_seed  in  LEN  initial LFSR state per symbol
- seed_err  out  1  one-cycle pulse when a zero seed is rejected
- start  in  1  begin spreading (level sampled in IDLE)
- stop  in  1  request stop at the next symbol end
- din_valid  in  1  data bit offered
- din  in  1  data bit
- din_ready  out  1  data bit accepted when din_valid and din_ready are both high
- chip_en  out  1  one-cycle strobe; chip_out and pn_out are valid
- chip_out  out  1  spread chip
- pn_out  out  1  raw PN chip
- epoch  out  1  high with chip_en on chip 0 of each symbol
- underrun  out  1  one-cycle pulse when a symbol starts with no buffered bit
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async): state=IDLE; poly=POLY_RST; seed=SEED_RST; lfsr, div_cnt, chip_cnt, nxt_full, cur_bit, stop_pend = 0.
- Reset values of outputs: chip_en, chip_out, pn_out, epoch, underrun, seed_err, din_ready, busy = 0; cfg_ready=1.
- Reset mid-operation aborts immediately; config returns to POLY_RST/SEED_RST.
- States: IDLE, LOAD, RUN, DRAIN.
- IDLE, config: cfg_valid&&cfg_ready with cfg_seed!=0 registers poly and seed. With cfg_seed==0, poly and seed are unchanged and seed_err pulses 1 cycle.
- IDLE, start: start -> LOAD. If config is accepted in the same cycle, LOAD uses the new values. stop is ignored in IDLE.
- LOAD (1 cycle): lfsr<=seed, chip_cnt<=0, div_cnt<=0, stop_pend<=0 -> RUN. nxt_full is preserved.
- RUN/DRAIN chip timing: div_cnt counts 0..CHIP_DIV-1 and wraps. tick = (div_cnt==CHIP_DIV-1). With CHIP_DIV=1, tick is high every cycle.
- Feedback: fb = lfsr[LEN-1] XOR (XOR over j=0..LEN-2 of poly[j+1]&lfsr[j]).
- On each tick (outputs registered, visible the cycle after the tick):
  - pn_out<=lfsr[LEN-1]; chip_out<=lfsr[LEN-1]^bit; chip_en<=1; epoch<=(chip_cnt==0).
  - bit: on chip_cnt==0, bit = nxt_bit if nxt_full, else 0. In that case cur_bit<=bit, nxt_full<=0, and underrun pulses if nxt_full was 0. On other chips, bit = cur_bit.
  - lfsr<={lfsr[LEN-2:0],fb}; chip_cnt<=chip_cnt+1.
  - When chip_cnt==N-1: lfsr<=seed and chip_cnt<=0, so every symbol restarts at the seed phase.
- Data buffer: one entry. din_ready = (state is RUN or DRAIN) && !nxt_full.
  - An accept sets nxt_full and latches nxt_bit.
  - A bit accepted in the same cycle as a chip-0 tick is not used for that symbol; it is kept for the next symbol and nxt_full ends at 1.
- stop in RUN -> DRAIN (stop_pend=1). start is ignored in RUN/DRAIN.
- DRAIN: the current symbol completes; the tick with chip_cnt==N-1 emits the final chip and moves to IDLE. The buffered nxt bit is retained.
- In IDLE and LOAD: chip_en=0, epoch=0, underrun=0; pn_out and chip_out hold their last values.

Test Plan:
- Reset defaults, CHIP_DIV=1, start, din=1 preloaded -> first 6 chip_en strobes give pn_out 1,0,0,0,0,1 and chip_out 0,1,1,1,1,0; epoch only on the first; chip_en continuous from the 3rd cycle after start.
- Run 3 symbols with bits 1,0,1 supplied on time -> pn_out is identical in each 31-chip window; chip_out is inverted in symbols 1 and 3; epoch at chips 0, 31, 62; underrun never asserted.
- Withhold din for symbol 2 -> underrun pulses once at chip 31; symbol 2 chip_out equals pn_out; din_ready stays high until a bit arrives.
- Config cfg_seed=0 in IDLE -> seed_err 1-cycle pulse, seed unchanged. Config poly=6'b101001, seed=5'b00001 -> first chip pn_out=0; the 31-chip sequence repeats each symbol.
- CHIP_DIV=4: chip_en exactly every 4 clocks. Assert stop at chip 10 -> chips continue to chip 30, then busy=0 and no further chip_en.
- Assert rst asynchronously mid-symbol -> all outputs 0 immediately, cfg_ready=1; a restart reproduces the reset-default sequence 1,0,0,0,0,1.
